// File: rtl/mock_fakeram_folded.sv
// Flop-based SRAM stand-in: XOR-folded row index, byte-masked writes, self-clearing rows.
// Latency READ_LATENCY cycles to rd_out/rd_valid_out; no backpressure, accesses ignored while busy_out.
module mock_fakeram_folded #(
    parameter int BITS         = 32,
    parameter int WORD_DEPTH   = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int ROWS_LOG2    = 2,
    parameter int READ_LATENCY = 1,
    parameter int WMASK_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS/8-1:0]     wmask_in,
    input  logic                  clear_req,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    output logic                  busy_out
);
    localparam int ROWS  = 1 << ROWS_LOG2;
    localparam int LANES = BITS / 8;

    if (BITS % 8 != 0 || ROWS_LOG2 < 1 || ROWS_LOG2 > ADDR_WIDTH ||
        READ_LATENCY < 1 || READ_LATENCY > 3 || WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_param
        $error("mock_fakeram_folded: illegal parameter combination");
    end

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                 state_q, state_d;
    logic [ROWS_LOG2-1:0]   clr_row_q, clr_row_d;
    logic [BITS-1:0]        mem_q [ROWS];
    logic [ROWS_LOG2-1:0]   idx;
    logic                   acc, wr_acc, rd_acc, flush;
    logic [READ_LATENCY-1:0] vld_q, vld_in;
    logic [BITS-1:0]        dat_q  [READ_LATENCY];
    logic [BITS-1:0]        dat_in [READ_LATENCY];

    // Address bit b lands on row-index bit b mod ROWS_LOG2: same as XOR of zero-extended chunks.
    always_comb begin
        idx = '0;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            idx[b % ROWS_LOG2] = idx[b % ROWS_LOG2] ^ addr_in[b];
        end
    end

    assign busy_out = (state_q == ST_CLEAR);
    assign acc      = ce_in & ~busy_out;
    assign wr_acc   = acc & we_in;
    assign rd_acc   = acc & ~we_in;
    assign flush    = (state_q == ST_READY) & clear_req;

    always_comb begin
        state_d   = state_q;
        clr_row_d = clr_row_q;
        case (state_q)
            ST_CLEAR: begin
                clr_row_d = clr_row_q + 1'b1;
                if (clr_row_q == ROWS_LOG2'(ROWS - 1)) begin
                    state_d   = ST_READY;
                    clr_row_d = '0;
                end
            end
            default: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_row_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_row_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_row_q <= clr_row_d;
        end
    end

    // Storage is deliberately unreset; the CLEAR sweep makes contents deterministic.
    always_ff @(posedge clk) begin
        if (busy_out) begin
            mem_q[clr_row_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask_in[i] || WMASK_EN == 0) begin
                    mem_q[idx][8*i +: 8] <= wd_in[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        vld_in    = '0;
        vld_in[0] = rd_acc;
        dat_in[0] = mem_q[idx];
        for (int s = 1; s < READ_LATENCY; s++) begin
            vld_in[s] = vld_q[s-1];
            dat_in[s] = dat_q[s-1];
        end
    end

    // Data stages only load with a valid, so rd_out holds between reads and across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                vld_q[s] <= vld_in[s] & ~flush;
                if (vld_in[s] && !flush) begin
                    dat_q[s] <= dat_in[s];
                end
            end
        end
    end

    assign rd_out       = dat_q[READ_LATENCY-1];
    assign rd_valid_out = vld_q[READ_LATENCY-1];
endmodule

// File: tb/tb_mock_fakeram_folded.sv
// Bench for mock_fakeram_folded: a latency-1 masked instance and a latency-3 unmasked instance
// share one stimulus stream; a reference model predicts read results into per-instance queues.
module tb_mock_fakeram_folded;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce    = 1'b0;
    logic        we    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wd    = '0;
    logic [3:0]  wmask = '0;
    logic        clr   = 1'b0;
    logic [31:0] rd_a, rd_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mock_fakeram_folded u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr), .wd_in(wd),
        .wmask_in(wmask), .clear_req(clr), .rd_out(rd_a), .rd_valid_out(vld_a), .busy_out(busy_a)
    );

    mock_fakeram_folded #(.READ_LATENCY(3), .WMASK_EN(0)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr), .wd_in(wd),
        .wmask_in(wmask), .clear_req(clr), .rd_out(rd_b), .rd_valid_out(vld_b), .busy_out(busy_b)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] m_a [4];
    logic [31:0] m_b [4];
    bit          m_busy = 1'b1;
    int          m_cnt  = 4;
    int          cyc    = 0;
    logic [1:0]  m_idx;
    exp_t        e;

    function automatic logic [1:0] fold(input logic [7:0] a);
        return a[1:0] ^ a[3:2] ^ a[5:4] ^ a[7:6];
    endfunction

    // Reference model: evaluates the inputs sampled at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b1;
            m_cnt  = 4;
            q_a.delete();
            q_b.delete();
            for (int r = 0; r < 4; r++) begin
                m_a[r] = '0;
                m_b[r] = '0;
            end
        end else begin
            cyc++;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) m_busy = 1'b0;
            end else begin
                m_idx = fold(addr);
                if (ce && we) begin
                    for (int l = 0; l < 4; l++) begin
                        if (wmask[l]) m_a[m_idx][8*l +: 8] = wd[8*l +: 8];
                    end
                    m_b[m_idx] = wd;
                end else if (ce) begin
                    e.d = m_a[m_idx]; e.due = cyc;     q_a.push_back(e);
                    e.d = m_b[m_idx]; e.due = cyc + 2; q_b.push_back(e);
                end
                if (clr) begin
                    q_a.delete();
                    q_b.delete();
                    m_busy = 1'b1;
                    m_cnt  = 4;
                    for (int r = 0; r < 4; r++) begin
                        m_a[r] = '0;
                        m_b[r] = '0;
                    end
                end
            end
        end
    end

    // Scoreboard: pops expected reads as each instance strobes rd_valid_out.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy_a !== m_busy || busy_b !== m_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d: l1=%b l3=%b expected %b", cyc, busy_a, busy_b, m_busy);
            end
            if (vld_a !== 1'b0) begin
                checks++;
                if (vld_a === 1'b1 && q_a.size() > 0 && q_a[0].due == cyc) begin
                    if (rd_a !== q_a[0].d) begin
                        errors++;
                        $display("FAIL rd_l1 cyc=%0d: got %h expected %h", cyc, rd_a, q_a[0].d);
                    end
                    void'(q_a.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_valid_l1 cyc=%0d: valid=%b data=%h", cyc, vld_a, rd_a);
                end
            end
            if (q_a.size() > 0 && q_a[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL missing_read_l1 cyc=%0d: expected %h due %0d", cyc, q_a[0].d, q_a[0].due);
                void'(q_a.pop_front());
            end
            if (vld_b !== 1'b0) begin
                checks++;
                if (vld_b === 1'b1 && q_b.size() > 0 && q_b[0].due == cyc) begin
                    if (rd_b !== q_b[0].d) begin
                        errors++;
                        $display("FAIL rd_l3 cyc=%0d: got %h expected %h", cyc, rd_b, q_b[0].d);
                    end
                    void'(q_b.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_valid_l3 cyc=%0d: valid=%b data=%h", cyc, vld_b, rd_b);
                end
            end
            if (q_b.size() > 0 && q_b[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL missing_read_l3 cyc=%0d: expected %h due %0d", cyc, q_b[0].d, q_b[0].due);
                void'(q_b.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        ce = 1'b1; we = 1'b1; addr = a; wd = d; wmask = m;
        step();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a);
        ce = 1'b1; we = 1'b0; addr = a;
        step();
        ce = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        step();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: pending l1=%0d l3=%0d expected 0", q_a.size(), q_b.size());
        end
    endtask

    task automatic busy_run(input string name);
        int n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 4 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy cycles %0d (l3 busy=%b) expected 4", name, n, busy_b);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (rd_a !== '0 || vld_a !== 1'b0 || busy_a !== 1'b1 ||
            rd_b !== '0 || vld_b !== 1'b0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: l1 rd=%h v=%b b=%b l3 rd=%h v=%b b=%b expected 0/0/1",
                     rd_a, vld_a, busy_a, rd_b, vld_b, busy_b);
        end
        rst_n = 1'b1;
        busy_run("reset_clear_len");
        do_read(8'hA7);
        checks++;
        if (vld_a !== 1'b1 || rd_a !== 32'h0) begin
            errors++;
            $display("FAIL first_read: valid=%b data=%h expected 1/00000000", vld_a, rd_a);
        end
        drain();
    endtask

    task automatic test_write_read();
        do_write(8'h00, 32'hDEADBEEF, 4'hF);
        do_read(8'h05);
        checks++;
        if (vld_a !== 1'b1 || rd_a !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: valid=%b data=%h expected 1/deadbeef", vld_a, rd_a);
        end
        drain();
    endtask

    task automatic test_byte_mask();
        do_write(8'h00, 32'h11223344, 4'b0101);
        do_read(8'h00);
        checks++;
        if (vld_a !== 1'b1 || rd_a !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_mask: valid=%b data=%h expected 1/de22be44", vld_a, rd_a);
        end
        step();
        step();
        checks++;
        if (vld_b !== 1'b1 || rd_b !== 32'h11223344) begin
            errors++;
            $display("FAIL mask_disabled: valid=%b data=%h expected 1/11223344", vld_b, rd_b);
        end
        drain();
    endtask

    task automatic test_alias();
        do_write(8'h01, 32'hAAAA0001, 4'hF);
        do_write(8'h04, 32'h55550004, 4'hF);
        do_read(8'h01);
        checks++;
        if (vld_a !== 1'b1 || rd_a !== 32'h55550004) begin
            errors++;
            $display("FAIL alias: valid=%b data=%h expected 1/55550004", vld_a, rd_a);
        end
        repeat (3) step();
        checks++;
        if (vld_a !== 1'b0 || rd_a !== 32'h55550004) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%h expected 0/55550004", vld_a, rd_a);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va, vb;
        logic [31:0] db [8];
        for (int i = 0; i < 4; i++) do_write(8'(i), 32'h10 + i, 4'hF);
        for (int i = 0; i < 8; i++) begin
            ce = (i < 4); we = 1'b0; addr = 8'(i);
            step();
            va[i] = vld_a; vb[i] = vld_b; db[i] = rd_b;
        end
        ce = 1'b0;
        checks++;
        if (va !== 8'b0000_1111) begin
            errors++;
            $display("FAIL b2b_valid_l1: pattern %b expected 00001111", va);
        end
        checks++;
        if (vb !== 8'b0011_1100) begin
            errors++;
            $display("FAIL b2b_valid_l3: pattern %b expected 00111100", vb);
        end
        for (int k = 2; k < 6; k++) begin
            checks++;
            if (db[k] !== 32'h10 + k - 2) begin
                errors++;
                $display("FAIL b2b_data_l3[%0d]: got %h expected %h", k, db[k], 32'h10 + k - 2);
            end
        end
        drain();
    endtask

    task automatic test_clear();
        logic [9:0] bz, va, vb;
        for (int i = 0; i < 10; i++) begin
            ce = (i < 4); we = 1'b0; addr = 8'(i); clr = (i == 2);
            step();
            bz[i] = busy_a; va[i] = vld_a; vb[i] = vld_b;
        end
        ce = 1'b0; clr = 1'b0;
        checks++;
        if (bz !== 10'b00_0011_1100) begin
            errors++;
            $display("FAIL clear_busy: pattern %b expected 0000111100", bz);
        end
        checks++;
        if (va !== 10'b00_0000_0011 || vb !== 10'b0) begin
            errors++;
            $display("FAIL clear_flush: l1 %b l3 %b expected 0000000011 / 0000000000", va, vb);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(8'(i));
            checks++;
            if (vld_a !== 1'b1 || rd_a !== 32'h0) begin
                errors++;
                $display("FAIL cleared_row%0d: valid=%b data=%h expected 1/00000000", i, vld_a, rd_a);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_clear();
        do_write(8'h02, 32'hCAFE0002, 4'hF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || vld_a !== 1'b0 || rd_a !== 32'h0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%b valid=%b data=%h l3busy=%b expected 1/0/0/1",
                     busy_a, vld_a, rd_a, busy_b);
        end
        step();
        step();
        rst_n = 1'b1;
        busy_run("reclear_len");
        do_read(8'h02);
        checks++;
        if (vld_a !== 1'b1 || rd_a !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_row: valid=%b data=%h expected 1/00000000", vld_a, rd_a);
        end
        drain();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_alias();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
